mem_arbiter: RTL

- Sequences and shares the single-port main data BRAM (11-bit byte address, funct3-sized access, registered 1-cycle read data) between two requesters: instruction fetch (IF) and load/store unit (LS).
- Performs range checking, load sign/zero extension and response buffering.
- Only one transaction is outstanding at a time.
- Sits between the core pipeline and the BRAM instance.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data BRAM between instruction fetch (IF)
// and the load/store unit (LS). One transaction in flight at a time; performs
// range/funct3 fault checks, load sign/zero extension and response holding.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin arbitration on simultaneous requests
//   undefined -> fixed priority, LS wins
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   if_req_valid/ready/addr            IF word-read request
//   if_rsp_valid/ready/data/err        IF response (held until consumed)
//   ls_req_valid/ready/write/funct3/addr/wdata   LS request
//   ls_rsp_valid/ready/data/err        LS response (held until consumed)
//   bram_write/funct3/din/addr         BRAM access strobes (valid in ACCESS)
//   bram_dout                          BRAM read data, one cycle after access
module mem_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [XLEN-1:0]   if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_write,
    input  logic [2:0]        ls_req_funct3,
    input  logic [XLEN-1:0]   ls_req_addr,
    input  logic [XLEN-1:0]   ls_req_wdata,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [XLEN-1:0]   ls_rsp_data,
    output logic              ls_rsp_err,
    output logic              bram_write,
    output logic [2:0]        bram_funct3,
    output logic [XLEN-1:0]   bram_din,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [XLEN-1:0]   bram_dout
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

    state_t            r_state;
    logic              r_owner_ls;
    logic              r_if_rsp_valid;
    logic              r_ls_rsp_valid;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_err;
    logic              r_bram_write;
    logic [2:0]        r_bram_funct3;
    logic [XLEN-1:0]   r_bram_din;
    logic [ADDR_W-1:0] r_bram_addr;

    logic              w_grant_ls;
    logic              w_grant_if;
    logic              w_idle;
    logic              w_accept;
    logic              w_sel_write;
    logic [2:0]        w_sel_funct3;
    logic [XLEN-1:0]   w_sel_addr;
    logic [XLEN-1:0]   w_sel_wdata;
    logic              w_f3_ok;
    logic [1:0]        w_size_m1;
    logic              w_hi_bad;
    logic [ADDR_W:0]   w_last;
    logic              w_fault;
    logic [XLEN-1:0]   w_fmt;
    logic              w_rsp_fire;

    // Arbitration: round-robin favours whoever was not granted last time
`ifdef MEM_ARB_RR_EN
    logic r_last_ls;
    assign w_grant_ls = ls_req_valid && (!if_req_valid || !r_last_ls);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_ls <= 1'b0;
        end else if (w_accept) begin
            r_last_ls <= w_grant_ls;
        end
    end
`else
    assign w_grant_ls = ls_req_valid;
`endif
    assign w_grant_if = if_req_valid && !w_grant_ls;

    // Ready is forced low while reset is asserted so every output reads 0
    assign w_idle       = reset_n && (r_state == S_IDLE);
    assign ls_req_ready = w_idle && w_grant_ls;
    assign if_req_ready = w_idle && w_grant_if;
    assign w_accept     = ls_req_ready || if_req_ready;

    // IF requests are always word loads
    assign w_sel_write  = w_grant_ls && ls_req_write;
    assign w_sel_funct3 = w_grant_ls ? ls_req_funct3 : F3_W;
    assign w_sel_addr   = w_grant_ls ? ls_req_addr   : if_req_addr;
    assign w_sel_wdata  = w_grant_ls ? ls_req_wdata  : '0;

    // Legal funct3 and access size minus one
    always_comb begin
        w_f3_ok   = 1'b0;
        w_size_m1 = 2'd0;
        case (w_sel_funct3)
            F3_B:    begin w_f3_ok = 1'b1;         w_size_m1 = 2'd0; end
            F3_H:    begin w_f3_ok = 1'b1;         w_size_m1 = 2'd1; end
            F3_W:    begin w_f3_ok = 1'b1;         w_size_m1 = 2'd3; end
            F3_BU:   begin w_f3_ok = !w_sel_write; w_size_m1 = 2'd0; end
            F3_HU:   begin w_f3_ok = !w_sel_write; w_size_m1 = 2'd1; end
            default: begin w_f3_ok = 1'b0;         w_size_m1 = 2'd0; end
        endcase
    end

    // Carry out of the last byte address means the access would wrap
    assign w_hi_bad = |w_sel_addr[XLEN-1:ADDR_W];
    assign w_last   = {1'b0, w_sel_addr[ADDR_W-1:0]} + (ADDR_W+1)'(w_size_m1);
    assign w_fault  = !w_f3_ok || w_hi_bad || w_last[ADDR_W];

    // Load result formatting from the access size latched on the BRAM port
    always_comb begin
        w_fmt = bram_dout;
        case (r_bram_funct3)
            F3_B:    w_fmt = {{(XLEN-8){bram_dout[7]}},   bram_dout[7:0]};
            F3_H:    w_fmt = {{(XLEN-16){bram_dout[15]}}, bram_dout[15:0]};
            F3_BU:   w_fmt = {{(XLEN-8){1'b0}},           bram_dout[7:0]};
            F3_HU:   w_fmt = {{(XLEN-16){1'b0}},          bram_dout[15:0]};
            default: w_fmt = bram_dout;
        endcase
    end

    assign w_rsp_fire = (r_if_rsp_valid && if_rsp_ready) ||
                        (r_ls_rsp_valid && ls_rsp_ready);

    // Transaction sequencer; bram_write is a one-cycle pulse during ACCESS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_owner_ls     <= 1'b0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_bram_write   <= 1'b0;
            r_bram_funct3  <= '0;
            r_bram_din     <= '0;
            r_bram_addr    <= '0;
        end else begin
            r_bram_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner_ls <= w_grant_ls;
                        if (w_fault) begin
                            r_rsp_data     <= '0;
                            r_rsp_err      <= 1'b1;
                            r_if_rsp_valid <= !w_grant_ls;
                            r_ls_rsp_valid <= w_grant_ls;
                            r_state        <= S_RESP;
                        end else begin
                            r_rsp_err     <= 1'b0;
                            r_bram_write  <= w_sel_write;
                            r_bram_funct3 <= w_sel_funct3;
                            r_bram_din    <= w_sel_wdata;
                            r_bram_addr   <= w_sel_addr[ADDR_W-1:0];
                            r_state       <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // The write strobe doubles as the latched store flag
                    if (r_bram_write) begin
                        r_rsp_data     <= '0;
                        r_if_rsp_valid <= !r_owner_ls;
                        r_ls_rsp_valid <= r_owner_ls;
                        r_state        <= S_RESP;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_rsp_data     <= w_fmt;
                    r_if_rsp_valid <= !r_owner_ls;
                    r_ls_rsp_valid <= r_owner_ls;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_fire) begin
                        r_if_rsp_valid <= 1'b0;
                        r_ls_rsp_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_rsp_valid = r_if_rsp_valid;
    assign ls_rsp_valid = r_ls_rsp_valid;
    assign if_rsp_data  = r_rsp_data;
    assign ls_rsp_data  = r_rsp_data;
    assign if_rsp_err   = r_rsp_err;
    assign ls_rsp_err   = r_rsp_err;
    assign bram_write   = r_bram_write;
    assign bram_funct3  = r_bram_funct3;
    assign bram_din     = r_bram_din;
    assign bram_addr    = r_bram_addr;

endmodule
